npc_btb: RTL
============

NPC_BTB -- requirements
Module: npc_btb

Interface
REQ-001 Parameter XLEN, default 32: PC and target width.
REQ-002 Parameter BTB_DEPTH, default 16: BTB entries; power of two, at least 2. IDXW = log2(BTB_DEPTH).
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset; bits [1:0] are zero.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 stall_i  input  1  hold current PC.
REQ-007 flush_i  input  1  invalidate all BTB entries (fence.i).
REQ-008 redirect_valid_i  input  1  execute stage resolved a mispredict or JALR.
REQ-009 redirect_pc_i  input  XLEN  correct next PC.
REQ-010 upd_valid_i  input  1  resolved control-transfer instruction, update BTB.
REQ-011 upd_pc_i  input  XLEN  PC of the resolved instruction.
REQ-012 upd_target_i  input  XLEN  resolved target.
REQ-013 upd_taken_i  input  1  resolved direction.
REQ-014 pc_o  output  XLEN  current fetch PC (registered).
REQ-015 pred_taken_o  output  1  BTB predicts pc_o is a taken transfer.
REQ-016 pred_target_o  output  XLEN  predicted target for pc_o.

Function
REQ-017 Index = PC[IDXW+1:2]; tag = PC[XLEN-1:IDXW+2]; per entry: valid, tag, target, 2-bit counter.
REQ-018 Lookup on pc_o is combinational: hit = valid[idx] AND tag equal; pred_taken_o = hit AND ctr[idx][1]; pred_target_o = target[idx], or pc_o+4 on a miss.
REQ-019 Next PC priority per edge: redirect_valid_i -> redirect_pc_i; else stall_i -> hold; else pred_taken_o -> pred_target_o; else pc_o+4.
REQ-020 Redirect wins over a simultaneous stall.
REQ-021 Bits [1:0] of every value loaded into the PC register are forced to 00.
REQ-022 pc_o+4 wraps modulo 2^XLEN; FFFF_FFFC -> 0000_0000.
REQ-023 Update on upd_valid_i, hit (valid and tag match at upd_pc_i index): counter +1 if taken, -1 if not taken, saturating at 3 and 0; target overwritten only when taken.
REQ-024 Update on upd_valid_i, miss and taken: allocate (valid=1, tag, target, ctr=2'b10), replacing any occupant.
REQ-025 Update on upd_valid_i, miss and not taken: no state change.
REQ-026 BTB writes take effect at the next edge; a same-cycle lookup of the written index returns the old contents.
REQ-027 flush_i clears all valid bits at the next edge, overrides a simultaneous update, and does not affect the PC path.
REQ-028 stall_i does not block BTB updates or flush.
REQ-029 Latency: one cycle from redirect or update input to the visible effect.

Reset
REQ-030 rstn low asynchronously sets pc_o=RESET_PC and clears all valid bits, counters, tags and targets to 0.
REQ-031 Reset asserted mid-operation discards any pending update or redirect.
REQ-032 The first rising edge after release performs a normal next-PC step.

Structure
REQ-033 Counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the allocation value go in the shared package npc_pkg, alongside the existing NPC op encodings.
REQ-034 One sub-module, sat_ctr2: 2-bit saturating up/down next-value logic, instantiated per update path.
REQ-035 The BTB is flop arrays; no memory macro.

Verification
REQ-036 Reset: rstn low, RESET_PC=0x100 -> pc_o=0x100 and pred_taken_o=0; after release, 3 edges -> pc_o=0x10C.
REQ-037 Allocate and predict:
- Stimulus: upd pc=0x110, target=0x200, taken=1.
- Response: when pc_o=0x110, pred_taken_o=1 and the next pc_o=0x200.
REQ-038 Counter hysteresis:
- Two not-taken updates for 0x110: the first gives pred_taken_o=0 (ctr 01), the second gives ctr 00.
- Three taken updates then give ctr 11 (saturated).
REQ-039 Priority: redirect_valid_i=1 to 0x400 together with stall_i=1 and a predicted hit -> pc_o=0x400 next cycle.
REQ-040 Alias and flush:
- Update at 0x110 then at 0x150 (same index, BTB_DEPTH=16) -> 0x110 misses.
- flush_i together with an update -> all entries miss afterwards.
REQ-041 Wrap and alignment:
- pc_o=0xFFFF_FFFC, no hit -> next pc_o=0x0.
- redirect_pc_i=0x203 -> pc_o=0x200.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared encodings for the next-PC unit and its branch target buffer.
// Counter states, allocation value and next-PC source selection.
package npc_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ   = 2'b00,
    NPC_PRED  = 2'b01,
    NPC_HOLD  = 2'b10,
    NPC_REDIR = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Fresh entries start weakly taken
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/sat_ctr2.sv
// Two-bit saturating up/down counter, next-value logic only.
// Counts up on up_i, down otherwise; sticks at ST and SNT.
module sat_ctr2
  import npc_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       up_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/npc_btb.sv
// Fetch PC register with a direct-mapped branch target buffer.
// Lookup is combinational on pc_o; updates land at the next edge.
module npc_btb
  import npc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o
);

  localparam int IDXW = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDXW - 2;

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  npc_op_e         op;

  logic            valid_q [BTB_DEPTH];
  logic            valid_d [BTB_DEPTH];
  logic [TAGW-1:0] tag_q   [BTB_DEPTH];
  logic [TAGW-1:0] tag_d   [BTB_DEPTH];
  logic [XLEN-1:0] tgt_q   [BTB_DEPTH];
  logic [XLEN-1:0] tgt_d   [BTB_DEPTH];
  logic [1:0]      ctr_q   [BTB_DEPTH];
  logic [1:0]      ctr_d   [BTB_DEPTH];

  logic [IDXW-1:0] l_idx, u_idx;
  logic [TAGW-1:0] l_tag, u_tag;
  logic            l_hit, u_hit;
  logic [1:0]      u_ctr_nxt;
  logic            upd_lsb_unused;

  assign pc_o     = pc_q;
  assign pc_plus4 = pc_q + XLEN'(4);

  assign l_idx = pc_q[IDXW+1:2];
  assign l_tag = pc_q[XLEN-1:IDXW+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  assign pred_taken_o  = l_hit & ctr_q[l_idx][1];
  assign pred_target_o = l_hit ? tgt_q[l_idx] : pc_plus4;

  always_comb begin
    op = NPC_SEQ;
    priority case (1'b1)
      redirect_valid_i: op = NPC_REDIR;
      stall_i:          op = NPC_HOLD;
      pred_taken_o:     op = NPC_PRED;
      default:          op = NPC_SEQ;
    endcase
  end

  always_comb begin
    pc_d = pc_plus4;
    unique case (op)
      NPC_REDIR: pc_d = redirect_pc_i;
      NPC_HOLD:  pc_d = pc_q;
      NPC_PRED:  pc_d = pred_target_o;
      default:   pc_d = pc_plus4;
    endcase
    pc_d[1:0] = 2'b00;
  end

  assign u_idx          = upd_pc_i[IDXW+1:2];
  assign u_tag          = upd_pc_i[XLEN-1:IDXW+2];
  assign u_hit          = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign upd_lsb_unused = ^upd_pc_i[1:0];

  sat_ctr2 u_sat (
    .ctr_i (ctr_q[u_idx]),
    .up_i  (upd_taken_i),
    .ctr_o (u_ctr_nxt)
  );

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (flush_i) begin
      for (int i = 0; i < BTB_DEPTH; i++) valid_d[i] = 1'b0;
    end else if (upd_valid_i) begin
      if (u_hit) begin
        ctr_d[u_idx] = u_ctr_nxt;
        if (upd_taken_i) tgt_d[u_idx] = upd_target_i;
      end else if (upd_taken_i) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = upd_target_i;
        ctr_d[u_idx]   = CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end

endmodule
